ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_ascii_lut.sv | 80 ++++++++
 rtl/ps2_key_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key decoder.
package ps2_pkg;

  // Prefix and filler bytes of the set-2 scancode stream
  localparam logic [7:0] ScExt   = 8'hE0;
  localparam logic [7:0] ScBrk   = 8'hF0;
  localparam logic [7:0] ScPause = 8'hE1;

  // Modifier scancodes
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScCaps   = 8'h58;

  // Bytes following E1 before the pause event is emitted
  localparam logic [2:0] PauseSkip = 3'd7;

  // Flag bit positions inside the 32-bit event word
  localparam int unsigned FlagBrk   = 15;
  localparam int unsigned FlagExt   = 14;
  localparam int unsigned FlagShift = 13;
  localparam int unsigned FlagCtrl  = 12;
  localparam int unsigned FlagCaps  = 11;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } ps2_state_e;

  // Keyboard status/ack bytes that never form a key event on their own
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scancode to ASCII translation for non-extended keys.
module ps2_ascii_lut (
  input  logic [7:0] scancode_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);

  logic [7:0] letter;
  logic [7:0] plain;
  logic [7:0] shifted;

  // Letters follow shift^caps; every other key follows shift only
  always_comb begin
    letter  = 8'h00;
    plain   = 8'h00;
    shifted = 8'h00;
    case (scancode_i)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      8'h45: begin plain = "0"; shifted = ")"; end
      8'h16: begin plain = "1"; shifted = "!"; end
      8'h1E: begin plain = "2"; shifted = "@"; end
      8'h26: begin plain = "3"; shifted = "#"; end
      8'h25: begin plain = "4"; shifted = "$"; end
      8'h2E: begin plain = "5"; shifted = "%"; end
      8'h36: begin plain = "6"; shifted = "^"; end
      8'h3D: begin plain = "7"; shifted = "&"; end
      8'h3E: begin plain = "8"; shifted = "*"; end
      8'h46: begin plain = "9"; shifted = "("; end
      8'h4E: begin plain = "-"; shifted = "_"; end
      8'h55: begin plain = "="; shifted = "+"; end
      8'h54: begin plain = "["; shifted = "{"; end
      8'h5B: begin plain = "]"; shifted = "}"; end
      8'h5D: begin plain = 8'h5C; shifted = "|"; end
      8'h4C: begin plain = ";"; shifted = ":"; end
      8'h52: begin plain = "'"; shifted = 8'h22; end
      8'h41: begin plain = ","; shifted = "<"; end
      8'h49: begin plain = "."; shifted = ">"; end
      8'h4A: begin plain = "/"; shifted = "?"; end
      8'h0E: begin plain = 8'h60; shifted = "~"; end
      8'h29: begin plain = " "; shifted = " "; end
      8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
      8'h66: begin plain = 8'h08; shifted = 8'h08; end
      8'h0D: begin plain = 8'h09; shifted = 8'h09; end
      8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
      default: ;
    endcase
    if (letter != 8'h00) begin
      ascii_o = (shift_i ^ caps_i) ? (letter - 8'h20) : letter;
    end else begin
      ascii_o = shift_i ? shifted : plain;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: prefix FSM, modifier tracking and a FWFT event FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8  // power of two, at least 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    scancode_in,
  input  logic                          valid_in,
  output logic [31:0]                   event_data_out,
  output logic                          event_valid_out,
  input  logic                          event_pop_in,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          overflow_out,
  input  logic                          clear_overflow_in
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d, caps_q, caps_d, caps_held_q, caps_held_d;

  logic            emit;
  logic [7:0]      ev_code;
  logic            ev_ext, ev_brk;
  logic            shift_now;
  logic [7:0]      lut_ascii;
  logic [31:0]     ev_data;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            pop_ok, push_ok, full;

  // Prefix FSM: tracks E0/F0/E1 prefixes and decides when a byte completes an event
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev_code = scancode_in;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        StIdle: begin
          if (scancode_in == ScExt) state_d = StExt;
          else if (scancode_in == ScBrk) state_d = StBrk;
          else if (scancode_in == ScPause) begin
            state_d = StPause;
            skip_d  = PauseSkip;
          end else if (!is_filler(scancode_in)) emit = 1'b1;
        end
        StExt: begin
          if (scancode_in == ScBrk) state_d = StExtBrk;
          else if (scancode_in != ScExt) begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          if (scancode_in == ScExt) state_d = StExt;
          else if (scancode_in != ScBrk) begin
            emit    = 1'b1;
            ev_brk  = 1'b1;
            state_d = StIdle;
          end
        end
        StExtBrk: begin
          state_d = StIdle;
          if (scancode_in != ScExt && scancode_in != ScBrk) begin
            emit   = 1'b1;
            ev_ext = 1'b1;
            ev_brk = 1'b1;
          end
        end
        StPause: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit    = 1'b1;
            ev_code = ScPause;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Modifier updates take effect on the emitting byte so its own flags see them
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (emit) begin
      if (!ev_ext && ev_code == ScLShift) lshift_d = !ev_brk;
      if (!ev_ext && ev_code == ScRShift) rshift_d = !ev_brk;
      if (ev_code == ScCtrl) ctrl_d = !ev_brk;
      if (!ev_ext && ev_code == ScCaps) begin
        if (ev_brk) begin
          caps_held_d = 1'b0;
        end else begin
          // Typematic repeats arrive while held and must not toggle
          if (!caps_held_q) caps_d = !caps_q;
          caps_held_d = 1'b1;
        end
      end
    end
    shift_now = lshift_d | rshift_d;
  end

  ps2_ascii_lut u_ascii_lut (
    .scancode_i (ev_code),
    .shift_i    (shift_now),
    .caps_i     (caps_d),
    .ascii_o    (lut_ascii)
  );

  // Event word assembly
  always_comb begin
    ev_data            = '0;
    ev_data[7:0]       = ev_code;
    ev_data[FlagBrk]   = ev_brk;
    ev_data[FlagExt]   = ev_ext;
    ev_data[FlagShift] = shift_now;
    ev_data[FlagCtrl]  = ctrl_d;
    ev_data[FlagCaps]  = caps_d;
    ev_data[23:16]     = (ev_ext || ev_brk) ? 8'h00 : lut_ascii;
  end

  // FIFO control: a pop while full frees the slot the coincident push needs
  always_comb begin
    full       = (count_q == CntFull);
    pop_ok     = event_pop_in && (count_q != '0);
    push_ok    = emit && (!full || pop_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = clear_overflow_in ? 1'b0 : overflow_q;
    if (emit && !push_ok) overflow_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      skip_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) mem_q[wr_ptr_q] <= ev_data;
  end

  assign event_data_out  = mem_q[rd_ptr_q];
  assign event_valid_out = (count_q != '0);
  assign count_out       = count_q;
  assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder against a prefix-flag reference model.
module tb_ps2_key_decoder;

  localparam int Depth = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  scancode_in = 8'h00;
  logic        valid_in = 1'b0;
  logic [31:0] event_data_out;
  logic        event_valid_out;
  logic        event_pop_in = 1'b0;
  logic [3:0]  count_out;
  logic        overflow_out;
  logic        clear_overflow_in = 1'b0;

  ps2_key_decoder #(.FIFO_DEPTH(Depth)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .scancode_in       (scancode_in),
    .valid_in          (valid_in),
    .event_data_out    (event_data_out),
    .event_valid_out   (event_valid_out),
    .event_pop_in      (event_pop_in),
    .count_out         (count_out),
    .overflow_out      (overflow_out),
    .clear_overflow_in (clear_overflow_in)
  );

  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference tables
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46};
  logic [7:0] misc_sc [9] = '{8'h29, 8'h5A, 8'h05, 8'h06, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h7D};
  logic [7:0] mod_sc [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
  string lower_s = "abcdefghijklmnopqrstuvwxyz";
  string upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  string dnum_s  = "0123456789";
  string dsym_s  = ")!@#$%^&*(";

  // Model state: pending prefixes as two flags plus a pause countdown
  bit          m_ext, m_brk;
  int          m_pause;
  bit          m_lsh, m_rsh, m_ctrl, m_caps, m_held, m_ovf;
  logic [31:0] q [$];

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input bit sh, input bit cp);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) a = (sh ^ cp) ? 8'(upper_s[i]) : 8'(lower_s[i]);
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) a = sh ? 8'(dsym_s[i]) : 8'(dnum_s[i]);
    if (c == 8'h29) a = 8'h20;
    if (c == 8'h5A) a = 8'h0D;
    return a;
  endfunction

  task automatic make_event(input logic [7:0] c, input bit ext, input bit brk,
                            output logic [31:0] w);
    bit sh;
    logic [7:0] a;
    if (!ext && c == 8'h12) m_lsh = !brk;
    if (!ext && c == 8'h59) m_rsh = !brk;
    if (c == 8'h14) m_ctrl = !brk;
    if (!ext && c == 8'h58) begin
      if (brk) m_held = 0;
      else begin
        if (!m_held) m_caps = !m_caps;
        m_held = 1;
      end
    end
    sh = m_lsh | m_rsh;
    a = (!ext && !brk) ? ascii_of(c, sh, m_caps) : 8'h00;
    w = {8'h00, a, brk, ext, sh, m_ctrl, m_caps, 3'b000, c};
  endtask

  task automatic model_byte(input logic [7:0] b, output bit em, output logic [31:0] w);
    em = 0;
    w = '0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin
        em = 1;
        make_event(8'hE1, 0, 0, w);
      end
    end else if (b == 8'hE0) begin
      if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
      else begin m_ext = 1; m_brk = 0; end
    end else if (b == 8'hF0) begin
      if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
      else m_brk = 1;
    end else if (!m_ext && !m_brk && b == 8'hE1) begin
      m_pause = 7;
    end else if (!m_ext && !m_brk &&
                 (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      em = 0;
    end else begin
      em = 1;
      make_event(b, m_ext, m_brk, w);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] b, input bit p, input bit c,
                             input bit r);
    bit em, pop_ok, full;
    logic [31:0] w;
    if (r) begin
      m_ext = 0; m_brk = 0; m_pause = 0;
      m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_caps = 0; m_held = 0; m_ovf = 0;
      q.delete();
    end else begin
      em = 0;
      w = '0;
      if (v) model_byte(b, em, w);
      pop_ok = p && (q.size() != 0);
      full = (q.size() == Depth);
      if (c) m_ovf = 0;
      if (pop_ok) void'(q.pop_front());
      if (em) begin
        if (!full || pop_ok) q.push_back(w);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit p, input bit c, input bit r);
    rst_in = r;
    valid_in = v;
    scancode_in = b;
    event_pop_in = p;
    clear_overflow_in = c;
    model_cycle(v, b, p, c, r);
    @(posedge clk_in);
    #1;
    rst_in = 0;
    valid_in = 0;
    event_pop_in = 0;
    clear_overflow_in = 0;
    check_eq("valid", 32'(event_valid_out), 32'(q.size() != 0));
    check_eq("count", 32'(count_out), 32'(q.size()));
    check_eq("overflow", 32'(overflow_out), 32'(m_ovf));
    if (q.size() != 0) check_eq("head", event_data_out, q[0]);
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0, 0);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    check_eq(tag, event_data_out, exp);
    step(0, 8'h00, 1, 0, 0);
  endtask

  function automatic logic [7:0] pick_byte();
    int r, k;
    r = int'($urandom_range(0, 99));
    if (r < 10) return 8'hE0;
    if (r < 18) return 8'hF0;
    if (r < 20) return 8'hE1;
    if (r < 23) return (r == 21) ? 8'hAA : 8'h00;
    if (r < 33) return mod_sc[$urandom_range(0, 3)];
    k = int'($urandom_range(0, 44));
    if (k < 26) return letter_sc[k];
    if (k < 36) return digit_sc[k - 26];
    return misc_sc[k - 36];
  endfunction

  initial begin
    bit v, p, c, r;
    step(0, 8'h00, 0, 0, 1);
    check_eq("rst_count", 32'(count_out), 32'd0);
    check_eq("rst_valid", 32'(event_valid_out), 32'd0);
    check_eq("rst_ovf", 32'(overflow_out), 32'd0);

    // Make then break of 'a'
    send(8'h1C); send(8'hF0); send(8'h1C);
    pop_expect("a_make", 32'h0061001C);
    pop_expect("a_break", 32'h0000801C);

    // Shifted letter
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    pop_expect("lshift_make", 32'h00002012);
    pop_expect("shift_A", 32'h0041201C);
    pop_expect("lshift_break", 32'h00008012);

    // Caps lock with a typematic repeat
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    pop_expect("caps_make", 32'h00000858);
    pop_expect("caps_repeat", 32'h00000858);
    pop_expect("caps_break", 32'h00008858);
    pop_expect("caps_A", 32'h0041081C);
    step(0, 8'h00, 0, 0, 1);

    // Extended up arrow
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    pop_expect("up_make", 32'h00004075);
    pop_expect("up_break", 32'h0000C075);

    // Pause sequence collapses to one E1 make
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    pop_expect("pause", 32'h000000E1);

    // Overflow: nine makes without popping
    for (int i = 0; i < 9; i++) send(letter_sc[i]);
    check_eq("full_count", 32'(count_out), 32'd8);
    check_eq("full_ovf", 32'(overflow_out), 32'd1);
    check_eq("full_head", event_data_out, 32'h0061001C);
    step(1, 8'h1C, 1, 0, 0);
    check_eq("pushpop_count", 32'(count_out), 32'd8);
    check_eq("pushpop_head", event_data_out, 32'h00620032);
    step(1, 8'h05, 0, 1, 0);
    check_eq("set_wins", 32'(overflow_out), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    check_eq("ovf_cleared", 32'(overflow_out), 32'd0);

    // Reset beats every other input in the same cycle
    step(1, 8'h1C, 1, 1, 1);
    check_eq("rst_prio", 32'(count_out), 32'd0);

    // Reset discards a pending extended prefix
    send(8'hE0);
    step(0, 8'h00, 0, 0, 1);
    send(8'h75);
    pop_expect("rst_mid_prefix", 32'h00000075);

    // Random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 2) != 0);
      if (((cyc / 300) % 2) == 0) p = ($urandom_range(0, 3) == 0);
      else p = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      step(v, pick_byte(), p, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
